// File: rtl/operand_fetch.sv
//----------------------------------------------------------------------------
// operand_fetch: register-read stage with RAW bypass / load-use interlock.
// Build option: OPFETCH_FWD_EN enables the EX/MEM/WB bypass network.
// Revision: 1.0
//----------------------------------------------------------------------------
`default_nettype none

module operand_fetch #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5,
   parameter int CNT_W  = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [ADDR_W-1:0] in_rs1,
   input  logic [ADDR_W-1:0] in_rs2,
   input  logic [DATA_W-1:0] in_imm,
   input  logic [ADDR_W-1:0] in_rd,
   input  logic              in_rd_we,
   output logic [ADDR_W-1:0] r1_addr,
   output logic [ADDR_W-1:0] r2_addr,
   input  logic [DATA_W-1:0] r1_data,
   input  logic [DATA_W-1:0] r2_data,
   input  logic              ex_we,
   input  logic              ex_is_load,
   input  logic [ADDR_W-1:0] ex_addr,
   input  logic [DATA_W-1:0] ex_data,
   input  logic              mem_we,
   input  logic [ADDR_W-1:0] mem_addr,
   input  logic [DATA_W-1:0] mem_data,
   input  logic              wb_we,
   input  logic [ADDR_W-1:0] wb_addr,
   input  logic [DATA_W-1:0] wb_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_op1,
   output logic [DATA_W-1:0] out_op2,
   output logic [DATA_W-1:0] out_imm,
   output logic [ADDR_W-1:0] out_rd,
   output logic              out_rd_we,
   output logic [CNT_W-1:0]  stall_cnt
);

   logic              valid_q;
   logic [DATA_W-1:0] op1_q, op2_q, imm_q;
   logic [ADDR_W-1:0] rd_q;
   logic              rd_we_q;
   logic [CNT_W-1:0]  stall_cnt_q;

   logic              w_hazard;
   logic              w_accept;
   logic [DATA_W-1:0] w_op1;
   logic [DATA_W-1:0] w_op2;

   function automatic logic [DATA_W-1:0] resolve(input logic [ADDR_W-1:0] rs,
                                                 input logic [DATA_W-1:0] rf);
      if (rs == '0)
         resolve = '0;
`ifdef OPFETCH_FWD_EN
      else if (ex_we && !ex_is_load && ex_addr == rs)
         resolve = ex_data;
      else if (mem_we && mem_addr == rs)
         resolve = mem_data;
      else if (wb_we && wb_addr == rs)
         resolve = wb_data;
`endif
      else
         resolve = rf;
   endfunction

   // A producer at x0 never matches because the index is checked nonzero.
   function automatic logic dst_match(input logic [ADDR_W-1:0] dst);
      dst_match = (dst != '0) && ((dst == in_rs1) || (dst == in_rs2));
   endfunction

`ifdef OPFETCH_FWD_EN
   assign w_hazard = in_valid && ex_we && ex_is_load && dst_match(ex_addr);
`else
   assign w_hazard = in_valid && ((ex_we  && dst_match(ex_addr))  ||
                                  (mem_we && dst_match(mem_addr)) ||
                                  (wb_we  && dst_match(wb_addr)));
   logic w_unused;
   assign w_unused = ^{ex_is_load, ex_data, mem_data, wb_data};
`endif

   assign w_op1    = resolve(in_rs1, r1_data);
   assign w_op2    = resolve(in_rs2, r2_data);
   assign r1_addr  = in_rs1;
   assign r2_addr  = in_rs2;
   assign in_ready = !w_hazard && (!valid_q || out_ready);
   assign w_accept = in_valid && in_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q     <= 1'b0;
         op1_q       <= '0;
         op2_q       <= '0;
         imm_q       <= '0;
         rd_q        <= '0;
         rd_we_q     <= 1'b0;
         stall_cnt_q <= '0;
      end else begin
         if (w_accept) begin
            valid_q <= 1'b1;
            op1_q   <= w_op1;
            op2_q   <= w_op2;
            imm_q   <= in_imm;
            rd_q    <= in_rd;
            rd_we_q <= in_rd_we;
         end else if (out_ready) begin
            valid_q <= 1'b0;
         end
         if (w_hazard && (stall_cnt_q != '1))
            stall_cnt_q <= stall_cnt_q + 1'b1;
      end
   end

   assign out_valid = valid_q;
   assign out_op1   = op1_q;
   assign out_op2   = op2_q;
   assign out_imm   = imm_q;
   assign out_rd    = rd_q;
   assign out_rd_we = rd_we_q;
   assign stall_cnt = stall_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_operand_fetch.sv
//----------------------------------------------------------------------------
// tb_operand_fetch: directed plus random stimulus against a behavioural model.
// Revision: 1.0
//----------------------------------------------------------------------------
`default_nettype none

module tb_operand_fetch;

   localparam int DATA_W = 32;
   localparam int ADDR_W = 5;
   localparam int CNT_W  = 32;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic              rst, in_valid, in_rd_we, out_ready;
   logic              ex_we, ex_is_load, mem_we, wb_we;
   logic [ADDR_W-1:0] in_rs1, in_rs2, in_rd, ex_addr, mem_addr, wb_addr;
   logic [DATA_W-1:0] in_imm, r1_data, r2_data, ex_data, mem_data, wb_data;
   logic              in_ready, out_valid, out_rd_we;
   logic [ADDR_W-1:0] r1_addr, r2_addr, out_rd;
   logic [DATA_W-1:0] out_op1, out_op2, out_imm;
   logic [CNT_W-1:0]  stall_cnt;

   operand_fetch #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
      .in_rd(in_rd), .in_rd_we(in_rd_we),
      .r1_addr(r1_addr), .r2_addr(r2_addr),
      .r1_data(r1_data), .r2_data(r2_data),
      .ex_we(ex_we), .ex_is_load(ex_is_load), .ex_addr(ex_addr), .ex_data(ex_data),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_data(mem_data),
      .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_op1(out_op1), .out_op2(out_op2), .out_imm(out_imm),
      .out_rd(out_rd), .out_rd_we(out_rd_we),
      .stall_cnt(stall_cnt)
   );

   int errs   = 0;
   int checks = 0;

   // Model state of the EX-facing register.
   logic              m_valid, m_rd_we;
   logic [DATA_W-1:0] m_op1, m_op2, m_imm;
   logic [ADDR_W-1:0] m_rd;
   logic [CNT_W-1:0]  m_cnt;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic idle_inputs();
      rst = 0; in_valid = 0; in_rs1 = 0; in_rs2 = 0; in_imm = 0; in_rd = 0; in_rd_we = 0;
      r1_data = 0; r2_data = 0; out_ready = 1;
      ex_we = 0; ex_is_load = 0; ex_addr = 0; ex_data = 0;
      mem_we = 0; mem_addr = 0; mem_data = 0;
      wb_we = 0; wb_addr = 0; wb_data = 0;
   endtask

   // Producers listed oldest-last, so the first match in the list is the youngest.
   function automatic logic [DATA_W-1:0] model_src(input logic [ADDR_W-1:0] rs,
                                                   input logic [DATA_W-1:0] rf);
      logic              we[3];
      logic [ADDR_W-1:0] a[3];
      logic [DATA_W-1:0] d[3];
      we[0] = ex_we && !ex_is_load; a[0] = ex_addr;  d[0] = ex_data;
      we[1] = mem_we;               a[1] = mem_addr; d[1] = mem_data;
      we[2] = wb_we;                a[2] = wb_addr;  d[2] = wb_data;
      if (rs == 0) return '0;
`ifdef OPFETCH_FWD_EN
      for (int k = 0; k < 3; k++)
         if (we[k] && a[k] == rs) return d[k];
`endif
      return rf;
   endfunction

   function automatic logic model_hazard();
      logic              we[3];
      logic [ADDR_W-1:0] a[3];
      logic              hz;
      we[0] = ex_we;  a[0] = ex_addr;
      we[1] = mem_we; a[1] = mem_addr;
      we[2] = wb_we;  a[2] = wb_addr;
      hz = 0;
`ifdef OPFETCH_FWD_EN
      hz = ex_we && ex_is_load && ex_addr != 0 && (ex_addr == in_rs1 || ex_addr == in_rs2);
`else
      for (int k = 0; k < 3; k++)
         if (we[k] && a[k] != 0 && (a[k] == in_rs1 || a[k] == in_rs2)) hz = 1;
`endif
      return in_valid && hz;
   endfunction

   // One clock: check combinational outputs mid-cycle, advance the model, check state after the edge.
   task automatic cycle();
      logic hz, rdy;
      @(negedge clk);
      hz  = model_hazard();
      rdy = !hz && (!m_valid || out_ready);
      chk("in_ready", {63'd0, in_ready}, {63'd0, rdy});
      chk("r1_addr", 64'(r1_addr), 64'(in_rs1));
      chk("r2_addr", 64'(r2_addr), 64'(in_rs2));
      if (rst) begin
         m_valid = 0; m_op1 = 0; m_op2 = 0; m_imm = 0; m_rd = 0; m_rd_we = 0; m_cnt = 0;
      end else begin
         if (hz && m_cnt != {CNT_W{1'b1}}) m_cnt = m_cnt + 1;
         if (in_valid && rdy) begin
            m_valid = 1;
            m_op1   = model_src(in_rs1, r1_data);
            m_op2   = model_src(in_rs2, r2_data);
            m_imm   = in_imm;
            m_rd    = in_rd;
            m_rd_we = in_rd_we;
         end else if (out_ready) begin
            m_valid = 0;
         end
      end
      @(posedge clk);
      #1;
      chk("out_valid", {63'd0, out_valid}, {63'd0, m_valid});
      chk("out_op1", 64'(out_op1), 64'(m_op1));
      chk("out_op2", 64'(out_op2), 64'(m_op2));
      chk("out_imm", 64'(out_imm), 64'(m_imm));
      chk("out_rd", 64'(out_rd), 64'(m_rd));
      chk("out_rd_we", {63'd0, out_rd_we}, {63'd0, m_rd_we});
      chk("stall_cnt", 64'(stall_cnt), 64'(m_cnt));
   endtask

   task automatic issue(input logic [ADDR_W-1:0] rs1, input logic [ADDR_W-1:0] rs2,
                        input logic [DATA_W-1:0] d1, input logic [DATA_W-1:0] d2);
      in_valid = 1; in_rs1 = rs1; in_rs2 = rs2; r1_data = d1; r2_data = d2;
      in_imm = $urandom; in_rd = ADDR_W'($urandom); in_rd_we = 1'($urandom);
   endtask

   logic [DATA_W-1:0] held;
   logic [CNT_W-1:0]  cnt0;

   initial begin
      m_valid = 0; m_op1 = 0; m_op2 = 0; m_imm = 0; m_rd = 0; m_rd_we = 0; m_cnt = 0;
      idle_inputs();
      #1;

      // Reset for two cycles.
      rst = 1;
      cycle();
      cycle();
      rst = 0;
      chk("rst_valid", {63'd0, out_valid}, 64'd0);
      chk("rst_cnt", 64'(stall_cnt), 64'd0);
      cycle();
      chk("idle_ready", {63'd0, in_ready}, 64'd1);

      // Plain read, then back-to-back acceptance.
      issue(3, 4, 32'h11, 32'h22);
      cycle();
      chk("rf_op1", 64'(out_op1), 64'h11);
      chk("rf_op2", 64'(out_op2), 64'h22);
      issue(6, 7, 32'h66, 32'h77);
      cycle();
      chk("b2b_valid", {63'd0, out_valid}, 64'd1);
      chk("b2b_op1", 64'(out_op1), 64'h66);

`ifdef OPFETCH_FWD_EN
      issue(3, 4, 32'h11, 32'h22);
      ex_we = 1; ex_addr = 3; ex_data = 32'hAAAA;
      mem_we = 1; mem_addr = 3; mem_data = 32'hBBBB;
      cycle();
      chk("fwd_ex", 64'(out_op1), 64'hAAAA);
      ex_we = 0;
      cycle();
      chk("fwd_mem", 64'(out_op1), 64'hBBBB);
      mem_we = 0; wb_we = 1; wb_addr = 3; wb_data = 32'hCCCC;
      cycle();
      chk("fwd_wb", 64'(out_op1), 64'hCCCC);
      wb_we = 0;
      issue(0, 4, 32'h5555, 32'h22);
      ex_we = 1; ex_addr = 0; ex_data = 32'hFFFF;
      cycle();
      chk("x0_op1", 64'(out_op1), 64'd0);
      ex_we = 0;

      // Load-use interlock resolved by MEM forwarding one cycle later.
      cnt0 = stall_cnt;
      issue(1, 5, 32'h1, 32'h0);
      ex_we = 1; ex_is_load = 1; ex_addr = 5;
      cycle();
      chk("lu_cnt", 64'(stall_cnt - cnt0), 64'd1);
      ex_we = 0; ex_is_load = 0;
      mem_we = 1; mem_addr = 5; mem_data = 32'h1234;
      cycle();
      chk("lu_op2", 64'(out_op2), 64'h1234);
      mem_we = 0;
`else
      // Without bypass a WB match stalls, then reads the written regfile.
      cnt0 = stall_cnt;
      issue(3, 4, 32'h0, 32'h22);
      wb_we = 1; wb_addr = 3; wb_data = 32'hCCCC;
      cycle();
      chk("nf_cnt", 64'(stall_cnt - cnt0), 64'd1);
      wb_we = 0; r1_data = 32'hCCCC;
      cycle();
      chk("nf_op1", 64'(out_op1), 64'hCCCC);
      issue(0, 4, 32'h5555, 32'h22);
      ex_we = 1; ex_addr = 0; ex_data = 32'hFFFF;
      cycle();
      chk("x0_op1", 64'(out_op1), 64'd0);
      ex_we = 0;
`endif

      // Backpressure with a valid output, then reset mid-stall.
      issue(2, 3, 32'h9, 32'hA);
      cycle();
      held = out_op1;
      out_ready = 0;
      issue(4, 5, 32'hDEAD, 32'hBEEF);
      for (int i = 0; i < 3; i++) begin
         cycle();
         chk("hold_op1", 64'(out_op1), 64'(held));
      end
      rst = 1;
      cycle();
      chk("rst_stall", {63'd0, out_valid}, 64'd0);
      rst = 0; out_ready = 1;

      // Random traffic with small register indices to force collisions.
      for (int n = 0; n < 400; n++) begin
         rst        = ($urandom_range(0, 99) < 2);
         in_valid   = ($urandom_range(0, 9) < 8);
         in_rs1     = ADDR_W'($urandom_range(0, 7));
         in_rs2     = ADDR_W'($urandom_range(0, 7));
         in_imm     = $urandom;
         in_rd      = ADDR_W'($urandom);
         in_rd_we   = 1'($urandom);
         r1_data    = $urandom;
         r2_data    = $urandom;
         out_ready  = ($urandom_range(0, 9) < 7);
         ex_we      = 1'($urandom);
         ex_is_load = 1'($urandom);
         ex_addr    = ADDR_W'($urandom_range(0, 7));
         ex_data    = $urandom;
         mem_we     = 1'($urandom);
         mem_addr   = ADDR_W'($urandom_range(0, 7));
         mem_data   = $urandom;
         wb_we      = 1'($urandom);
         wb_addr    = ADDR_W'($urandom_range(0, 7));
         wb_data    = $urandom;
         cycle();
      end

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule

`default_nettype wire
